// File: rtl/wb_trace_checker.sv
// wb_trace_checker: compares the pipeline write-back trace against a programmed list of expected (rd, data) writes
module wb_trace_checker #(
  parameter int DEPTH   = 64,
  parameter int AW      = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   g_pc,
  input  logic [31:0]   g_instr,
  input  logic [31:0]   g_wb_data,
  input  logic [4:0]    g_rwd,
  input  logic          exp_we,
  input  logic [AW-1:0] exp_addr,
  input  logic [4:0]    exp_rd,
  input  logic [31:0]   exp_data,
  input  logic [AW:0]   exp_len,
  input  logic          start,
  output logic          done,
  output logic          pass,
  output logic [1:0]    fail_code,
  output logic [AW:0]   fail_idx,
  output logic [31:0]   fail_pc,
  output logic [31:0]   fail_instr,
  output logic [31:0]   fail_got,
  output logic [15:0]   wb_count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;
  state_t state_q, state_d;
  logic [AW:0] idx_q, idx_d, len_q, len_d, fidx_q, fidx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] code_q, code_d;
  logic [31:0] fpc_q, fpc_d, finstr_q, finstr_d, fgot_q, fgot_d;
  logic [36:0] mem_q [DEPTH];
  logic ev, hit, fire;
  logic [1:0] fire_code;
  logic [AW:0] fire_idx, len_c, idx_inc;
  logic [15:0] cnt_inc;
  // Bubbles and writes to $0 are not events; the entry for the current idx is read combinationally
  assign ev      = g_rwd != 5'd0;
  assign hit     = {g_rwd, g_wb_data} == mem_q[idx_q[AW-1:0]];
  assign len_c   = (exp_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : exp_len;
  assign idx_inc = idx_q + (AW+1)'(1);
  assign cnt_inc = cnt_q + 16'(cnt_q != 16'hFFFF);
  assign done       = state_q == PASS || state_q == FAIL;
  assign pass       = state_q == PASS;
  assign fail_code  = code_q;
  assign fail_idx   = fidx_q;
  assign fail_pc    = fpc_q;
  assign fail_instr = finstr_q;
  assign fail_got   = fgot_q;
  assign wb_count   = cnt_q;
  // Expectation memory: frozen while a check runs, survives reset
  always_ff @(posedge clk)
    if (exp_we && state_q != RUN) mem_q[exp_addr] <= {exp_rd, exp_data};
  // Next state: restart, in-order compare, hang watchdog and post-pass runaway detection
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    tmo_d     = tmo_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    fidx_d    = fidx_q;
    fpc_d     = fpc_q;
    finstr_d  = finstr_q;
    fgot_d    = fgot_q;
    fire      = 1'b0;
    fire_code = 2'd0;
    fire_idx  = idx_q;
    if (start && state_q != RUN) begin
      state_d  = (len_c == '0) ? PASS : RUN;
      len_d    = len_c;
      idx_d    = '0;
      tmo_d    = '0;
      cnt_d    = '0;
      code_d   = '0;
      fidx_d   = '0;
      fpc_d    = '0;
      finstr_d = '0;
      fgot_d   = '0;
    end else if (state_q == RUN) begin
      if (ev) begin
        cnt_d = cnt_inc;
        if (hit) begin
          idx_d   = idx_inc;
          tmo_d   = '0;
          state_d = (idx_inc == len_q) ? PASS : RUN;
        end else begin
          fire      = 1'b1;
          fire_code = 2'd1;
        end
      end else if (tmo_q == TW'(TIMEOUT - 1)) begin
        fire      = 1'b1;
        fire_code = 2'd2;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else if (state_q == PASS && ev) begin
      cnt_d     = cnt_inc;
      fire      = 1'b1;
      fire_code = 2'd3;
      fire_idx  = len_q;
    end
    if (fire) begin
      state_d  = FAIL;
      code_d   = fire_code;
      fidx_d   = fire_idx;
      fpc_d    = g_pc;
      finstr_d = g_instr;
      fgot_d   = g_wb_data;
    end
  end
  // State and report registers, cleared by reset
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      fidx_q   <= '0;
      fpc_q    <= '0;
      finstr_q <= '0;
      fgot_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      fidx_q   <= fidx_d;
      fpc_q    <= fpc_d;
      finstr_q <= finstr_d;
      fgot_q   <= fgot_d;
    end
endmodule

// File: tb/tb_wb_trace_checker.sv
// tb_wb_trace_checker: directed and random trace stimulus against a queue-based reference model
module tb_wb_trace_checker;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] g_pc = '0, g_instr = '0, g_wb_data = '0, exp_data = '0;
  logic [4:0] g_rwd = '0, exp_rd = '0;
  logic exp_we = 1'b0, start = 1'b0;
  logic [5:0] exp_addr = '0;
  logic [6:0] exp_len = '0;
  logic done, pass;
  logic [1:0] fail_code;
  logic [6:0] fail_idx;
  logic [31:0] fail_pc, fail_instr, fail_got;
  logic [15:0] wb_count;
  int checks = 0, errors = 0;
  // Reference model: a copy of the expectation memory, a queue of outstanding writes and a quiet-cycle count
  logic [36:0] mm [64];
  logic [36:0] m_q [$];
  int m_st = 0, m_len = 0, m_matched = 0, m_quiet = 0, m_cnt = 0, m_code = 0, m_fidx = 0;
  logic [31:0] m_pc = '0, m_instr = '0, m_got = '0;

  wb_trace_checker #(.DEPTH(64), .AW(6), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .g_pc(g_pc), .g_instr(g_instr), .g_wb_data(g_wb_data),
    .g_rwd(g_rwd), .exp_we(exp_we), .exp_addr(exp_addr), .exp_rd(exp_rd), .exp_data(exp_data),
    .exp_len(exp_len), .start(start), .done(done), .pass(pass), .fail_code(fail_code),
    .fail_idx(fail_idx), .fail_pc(fail_pc), .fail_instr(fail_instr), .fail_got(fail_got),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_fail(input int code, input int idx);
    m_st = 3;
    m_code = code;
    m_fidx = idx;
    m_pc = g_pc;
    m_instr = g_instr;
    m_got = g_wb_data;
  endtask

  task automatic model();
    if (!rst_n) begin
      m_st = 0; m_len = 0; m_matched = 0; m_quiet = 0; m_cnt = 0; m_code = 0; m_fidx = 0;
      m_pc = '0; m_instr = '0; m_got = '0;
      m_q.delete();
    end else begin
      if (exp_we && m_st != 1) mm[exp_addr] = {exp_rd, exp_data};
      if (start && m_st != 1) begin
        m_len = (exp_len > 64) ? 64 : int'(exp_len);
        m_q.delete();
        for (int i = 0; i < m_len; i++) m_q.push_back(mm[i]);
        m_matched = 0; m_quiet = 0; m_cnt = 0; m_code = 0; m_fidx = 0;
        m_pc = '0; m_instr = '0; m_got = '0;
        m_st = (m_len == 0) ? 2 : 1;
      end else if (m_st == 1) begin
        if (g_rwd != 0) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_q[0] == {g_rwd, g_wb_data}) begin
            void'(m_q.pop_front());
            m_matched++;
            m_quiet = 0;
            if (m_q.size() == 0) m_st = 2;
          end else m_fail(1, m_matched);
        end else begin
          m_quiet++;
          if (m_quiet == TMO) m_fail(2, m_matched);
        end
      end else if (m_st == 2 && g_rwd != 0) begin
        if (m_cnt < 65535) m_cnt++;
        m_fail(3, m_len);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("done", 32'(done), 32'(m_st >= 2));
    chk("pass", 32'(pass), 32'(m_st == 2));
    chk("fail_code", 32'(fail_code), m_code);
    chk("fail_idx", 32'(fail_idx), m_fidx);
    chk("fail_pc", fail_pc, m_pc);
    chk("fail_instr", fail_instr, m_instr);
    chk("fail_got", fail_got, m_got);
    chk("wb_count", 32'(wb_count), m_cnt);
    g_pc = $urandom;
    g_instr = $urandom;
  endtask

  task automatic load(input int addr, input int rd, input logic [31:0] data);
    exp_we = 1'b1; exp_addr = 6'(addr); exp_rd = 5'(rd); exp_data = data;
    tick();
    exp_we = 1'b0;
  endtask

  task automatic go(input int len);
    exp_len = 7'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic ev(input int rd, input logic [31:0] data);
    g_rwd = 5'(rd); g_wb_data = data;
    tick();
    g_rwd = '0; g_wb_data = $urandom;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int quiet_left;
    logic [36:0] e;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) load(i, $urandom_range(1, 31), $urandom);
    load(0, 8, 32'h5); load(1, 9, 32'hA); load(2, 10, 32'hF);
    go(3); ev(8, 32'h5); idle(1); ev(9, 32'hA); ev(10, 32'hF);
    chk("match_pass", 32'(pass), 1); chk("match_cnt", 32'(wb_count), 3);
    idle(2);
    go(3); ev(8, 32'h5); ev(9, 32'hB);
    chk("mm_code", 32'(fail_code), 1); chk("mm_idx", 32'(fail_idx), 1); chk("mm_got", fail_got, 32'hB);
    ev(10, 32'hF); idle(2);
    chk("mm_hold_cnt", 32'(wb_count), 2);
    load(1, 9, 32'hB);
    go(3); chk("restart_clear", 32'(fail_code), 0);
    ev(8, 32'h5); ev(9, 32'hB); ev(10, 32'hF);
    chk("restart_pass", 32'(pass), 1);
    go(3); ev(8, 32'h5); idle(TMO - 1);
    chk("hang_early", 32'(fail_code), 0);
    idle(1);
    chk("hang_code", 32'(fail_code), 2); chk("hang_idx", 32'(fail_idx), 1);
    go(1); ev(8, 32'h5); chk("extra_pass", 32'(pass), 1);
    ev(3, 32'h0);
    chk("extra_code", 32'(fail_code), 3); chk("extra_idx", 32'(fail_idx), 1); chk("extra_cnt", 32'(wb_count), 2);
    go(0); chk("len0_pass", 32'(pass), 1);
    go(3); ev(8, 32'h5); load(1, 9, 32'h77);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_done", 32'(done), 0);
    go(3); ev(8, 32'h5); ev(9, 32'hB); ev(10, 32'hF);
    chk("we_run_ignored", 32'(pass), 1);
    for (int i = 0; i < 64; i++) load(i, $urandom_range(1, 31), $urandom);
    go(100);
    for (int i = 0; i < 64; i++) begin
      e = m_q[0];
      ev(e[36:32], e[31:0]);
    end
    chk("clamp_pass", 32'(pass), 1); chk("clamp_cnt", 32'(wb_count), 64);
    quiet_left = 0;
    for (int c = 0; c < 4000; c++) begin
      exp_we = ($urandom_range(0, 15) == 0);
      exp_addr = 6'($urandom_range(0, 15));
      exp_rd = 5'($urandom_range(1, 31));
      exp_data = $urandom_range(0, 3);
      start = ($urandom_range(0, 59) == 0) || (m_st >= 2 && $urandom_range(0, 7) == 0);
      exp_len = ($urandom_range(0, 19) == 0) ? 7'($urandom_range(64, 127)) : 7'($urandom_range(0, 13));
      g_rwd = '0;
      g_wb_data = $urandom;
      if (quiet_left > 0) quiet_left--;
      else if ($urandom_range(0, 49) == 0) quiet_left = $urandom_range(TMO - 3, TMO + 2);
      else if ($urandom_range(0, 2) != 0) begin
        if (m_st == 1 && m_q.size() > 0 && $urandom_range(0, 19) != 0) begin
          e = m_q[0];
          g_rwd = e[36:32];
          g_wb_data = e[31:0];
        end else if (m_st != 2 || $urandom_range(0, 3) == 0) begin
          g_rwd = 5'($urandom_range(1, 31));
          g_wb_data = $urandom_range(0, 3);
        end
      end
      tick();
    end
    exp_we = 1'b0; start = 1'b0; g_rwd = '0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
